// File: rtl/hs_unit_dff_pipe.sv
`default_nettype none
// ============================================================================
// Module   : hs_unit_dff_pipe
// Brief    : Valid/ready register pipeline with bubble collapsing, global
//            clock enable and occupancy count. Optional synchronous flush
//            is enabled with macro HS_UNIT_DFF_PIPE_FLUSH_EN.
// Revision : 1.0 - initial release
// ============================================================================
module hs_unit_dff_pipe #(
    parameter type      DATA_TYPE   = logic,
    parameter DATA_TYPE RESET_VALUE = 1'b0,
    parameter int       STAGES      = 2,
    parameter int       CNT_W       = $clog2(STAGES + 1)
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             ce,
`ifdef HS_UNIT_DFF_PIPE_FLUSH_EN
    input  logic             flush,
`endif
    input  logic             in_valid,
    output logic             in_ready,
    input  DATA_TYPE         in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output DATA_TYPE         out_data,
    output logic [CNT_W-1:0] occupancy
);

    generate
        if (STAGES < 1 || STAGES > 16) begin : g_bad_stages
            $error("hs_unit_dff_pipe: STAGES must be within 1..16");
        end
        if (CNT_W != $clog2(STAGES + 1)) begin : g_bad_cnt_w
            $error("hs_unit_dff_pipe: CNT_W is derived and must not be overridden");
        end
    endgenerate

    localparam int c_LAST = STAGES - 1;

    logic              w_flush;
    logic              w_act;
    logic [STAGES:0]   w_ready;
    logic [STAGES-1:0] w_up_valid;
    DATA_TYPE          w_up_data [STAGES];
    logic              w_in_fire;
    logic              w_out_fire;

    logic [STAGES-1:0] r_valid;
    DATA_TYPE          r_data [STAGES];
    logic [CNT_W-1:0]  r_occupancy;

`ifdef HS_UNIT_DFF_PIPE_FLUSH_EN
    assign w_flush = ce & flush;
`else
    assign w_flush = 1'b0;
`endif

    // A flush cycle behaves like a stalled cycle at the ports: no handshakes.
    assign w_act = ce & ~w_flush;

    // Ready ripples from the output side; an empty stage always accepts,
    // which is what squeezes bubbles out while the sink is stalled.
    always_comb begin
        w_ready         = '0;
        w_ready[STAGES] = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            w_ready[k] = w_act & (~r_valid[k] | w_ready[k+1]);
        end
    end

    always_comb begin
        w_up_valid    = '0;
        w_up_valid[0] = in_valid;
        w_up_data[0]  = in_data;
        for (int k = 1; k < STAGES; k++) begin
            w_up_valid[k] = r_valid[k-1];
            w_up_data[k]  = r_data[k-1];
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            r_valid <= '0;
            for (int k = 0; k < STAGES; k++) begin
                r_data[k] <= RESET_VALUE;
            end
        end else if (w_flush) begin
            r_valid <= '0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (w_ready[k]) begin
                    r_valid[k] <= w_up_valid[k];
                    if (w_up_valid[k]) begin
                        r_data[k] <= w_up_data[k];
                    end
                end
            end
        end
    end

    assign in_ready   = w_ready[0];
    assign out_valid  = w_act & r_valid[c_LAST];
    assign out_data   = r_data[c_LAST];
    assign w_in_fire  = in_valid & in_ready;
    assign w_out_fire = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (srst) begin
            r_occupancy <= '0;
        end else if (w_flush) begin
            r_occupancy <= '0;
        end else begin
            case ({w_in_fire, w_out_fire})
                2'b10:   r_occupancy <= r_occupancy + CNT_W'(1);
                2'b01:   r_occupancy <= r_occupancy - CNT_W'(1);
                default: r_occupancy <= r_occupancy;
            endcase
        end
    end

    assign occupancy = r_occupancy;

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!srst) begin
            assert (r_occupancy <= CNT_W'(STAGES));
            assert (32'(r_occupancy) == 32'($countones(r_valid)));
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_hs_unit_dff_pipe.sv
`default_nettype none
// Directed self-checking bench: a 3-stage and a 4-stage instance with an
// 8-bit payload, exercised one after the other on a shared clock/reset/ce.
module tb_hs_unit_dff_pipe;

    typedef logic [7:0] byte_t;

    logic  clk;
    logic  srst;
    logic  ce;
    logic  flush;

    logic  v3, ir3, ov3, or3;
    byte_t d3, od3;
    logic [1:0] occ3;

    logic  v4, ir4, ov4, or4;
    byte_t d4, od4;
    logic [2:0] occ4;

    int n_checks = 0;
    int n_errors = 0;

    hs_unit_dff_pipe #(
        .DATA_TYPE   (byte_t),
        .RESET_VALUE (8'h3C),
        .STAGES      (3)
    ) u_dut3 (
        .clk       (clk),
        .srst      (srst),
        .ce        (ce),
`ifdef HS_UNIT_DFF_PIPE_FLUSH_EN
        .flush     (flush),
`endif
        .in_valid  (v3),
        .in_ready  (ir3),
        .in_data   (d3),
        .out_valid (ov3),
        .out_ready (or3),
        .out_data  (od3),
        .occupancy (occ3)
    );

    hs_unit_dff_pipe #(
        .DATA_TYPE   (byte_t),
        .RESET_VALUE (8'h3C),
        .STAGES      (4)
    ) u_dut4 (
        .clk       (clk),
        .srst      (srst),
        .ce        (ce),
`ifdef HS_UNIT_DFF_PIPE_FLUSH_EN
        .flush     (1'b0),
`endif
        .in_valid  (v4),
        .in_ready  (ir4),
        .in_data   (d4),
        .out_valid (ov4),
        .out_ready (or4),
        .out_data  (od4),
        .occupancy (occ4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        srst  = 1'b1;
        ce    = 1'b1;
        flush = 1'b0;
        v3 = 1'b1; d3 = 8'hA5; or3 = 1'b1;
        v4 = 1'b1; d4 = 8'hA5; or4 = 1'b1;

        // Reset held two cycles with valid input present
        tick();
        tick();
        chk("rst_ov3",  ov3,  0);
        chk("rst_od3",  od3,  8'h3C);
        chk("rst_occ3", occ3, 0);
        chk("rst_ov4",  ov4,  0);
        chk("rst_od4",  od4,  8'h3C);
        chk("rst_occ4", occ4, 0);
        srst = 1'b0;
        v3 = 1'b0;
        v4 = 1'b0;
        #1;
        chk("rst_ir3", ir3, 1);
        chk("rst_ir4", ir4, 1);

        // Streaming through 3 stages
        v3 = 1'b1; d3 = 8'd1;
        tick();
        chk("str_occ_a", occ3, 1);
        chk("str_ov_a",  ov3,  0);
        d3 = 8'd2;
        tick();
        chk("str_occ_b", occ3, 2);
        chk("str_ov_b",  ov3,  0);
        d3 = 8'd3;
        tick();
        chk("str_ov_c",  ov3,  1);
        chk("str_od_c",  od3,  8'd1);
        chk("str_occ_c", occ3, 3);
        d3 = 8'd4;
        tick();
        chk("str_od_d",  od3,  8'd2);
        chk("str_occ_d", occ3, 3);
        v3 = 1'b0;
        tick();
        chk("str_od_e",  od3,  8'd3);
        chk("str_occ_e", occ3, 2);
        tick();
        chk("str_od_f",  od3,  8'd4);
        chk("str_occ_f", occ3, 1);
        tick();
        chk("str_ov_g",  ov3,  0);
        chk("str_occ_g", occ3, 0);

        // Backpressure fill of 4 stages
        or4 = 1'b0;
        v4  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            d4 = byte_t'(10 + i);
            #1;
            chk("bp_ir_fill", ir4, 1);
            tick();
        end
        chk("bp_occ_full", occ4, 4);
        chk("bp_ov_full",  ov4,  1);
        chk("bp_od_full",  od4,  8'd10);
        d4 = 8'd14;
        #1;
        chk("bp_ir_5th", ir4, 0);
        tick();
        chk("bp_occ_hold", occ4, 4);
        chk("bp_od_hold",  od4,  8'd10);
        or4 = 1'b1;
        #1;
        chk("bp_ir_rel", ir4, 1);
        tick();
        chk("bp_od_11",  od4,  8'd11);
        chk("bp_occ_11", occ4, 4);
        v4 = 1'b0;
        tick();
        chk("bp_od_12",  od4,  8'd12);
        chk("bp_occ_12", occ4, 3);
        tick();
        chk("bp_od_13",  od4,  8'd13);
        chk("bp_occ_13", occ4, 2);
        tick();
        chk("bp_od_14",  od4,  8'd14);
        chk("bp_occ_14", occ4, 1);
        tick();
        chk("bp_ov_end",  ov4,  0);
        chk("bp_occ_end", occ4, 0);

        // Bubble collapse while the sink is stalled
        or3 = 1'b0;
        v3 = 1'b1; d3 = 8'd5;
        tick();
        v3 = 1'b0;
        tick();
        v3 = 1'b1; d3 = 8'd6;
        tick();
        v3 = 1'b0;
        tick();
        tick();
        chk("bub_occ", occ3, 2);
        chk("bub_ov",  ov3,  1);
        chk("bub_od",  od3,  8'd5);
        chk("bub_ir",  ir3,  1);
        or3 = 1'b1;
        tick();
        chk("bub_od6",  od3,  8'd6);
        chk("bub_ov6",  ov3,  1);
        chk("bub_occ6", occ3, 1);
        tick();
        chk("bub_ov_end",  ov3,  0);
        chk("bub_occ_end", occ3, 0);

        // Clock-enable stall with two items in flight
        v3 = 1'b1; d3 = 8'd7;
        tick();
        d3 = 8'd8;
        tick();
        chk("ce_occ_pre", occ3, 2);
        d3 = 8'd9;
        ce = 1'b0;
        #1;
        chk("ce_ir_off", ir3, 0);
        chk("ce_ov_off", ov3, 0);
        for (int i = 0; i < 5; i++) tick();
        chk("ce_occ_frz", occ3, 2);
        chk("ce_ir_frz",  ir3,  0);
        chk("ce_ov_frz",  ov3,  0);
        ce = 1'b1;
        v3 = 1'b0;
        tick();
        chk("ce_od7",  od3,  8'd7);
        chk("ce_ov7",  ov3,  1);
        tick();
        chk("ce_od8",  od3,  8'd8);
        chk("ce_occ8", occ3, 1);
        tick();
        chk("ce_ov_end",  ov3,  0);
        chk("ce_occ_end", occ3, 0);

`ifdef HS_UNIT_DFF_PIPE_FLUSH_EN
        // Flush of a full pipe with an input offered in the same cycle
        or3 = 1'b0;
        v3  = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            d3 = byte_t'(i);
            tick();
        end
        chk("fl_occ_pre", occ3, 3);
        flush = 1'b1;
        d3 = 8'd9;
        #1;
        chk("fl_ir", ir3, 0);
        chk("fl_ov", ov3, 0);
        tick();
        flush = 1'b0;
        v3 = 1'b0;
        or3 = 1'b1;
        #1;
        chk("fl_occ", occ3, 0);
        chk("fl_ov_after", ov3, 0);
        chk("fl_ir_after", ir3, 1);
        for (int i = 0; i < 3; i++) tick();
        chk("fl_no9_ov",  ov3,  0);
        chk("fl_no9_occ", occ3, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
